rr_queue_bank: RTL and testbench

//  Three-queue ingress buffer feeding the round-robin scheduler.
//  - Accepts words from one ingress port, tagged with a queue id, into 3 independent FIFOs.
//  - Drives q0_rdy/q1_rdy/q2_rdy (queue non-empty) to the scheduler.
//  - Pops the queue named by the scheduler's one-hot sel; the popped word goes out on a registered egress port.

---
 rtl/rr_queue_bank.sv | 113 +++++++++++
 tb/tb_rr_queue_bank.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/rr_queue_bank.sv
// Three independent FIFOs behind a single tagged ingress port. Words leave through a
// registered egress port when the scheduler issues a one-hot pop.
module rr_queue_bank #(
    parameter int unsigned DW    = 8,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_vld,
    input  logic [1:0]    in_qid,
    input  logic [DW-1:0] in_data,
    output logic          in_rdy,
    output logic          q0_rdy,
    output logic          q1_rdy,
    output logic          q2_rdy,
    input  logic [2:0]    sel,
    output logic          out_vld,
    output logic [1:0]    out_qid,
    output logic [DW-1:0] out_data,
    output logic [AW:0]   q0_cnt,
    output logic [AW:0]   q1_cnt,
    output logic [AW:0]   q2_cnt,
    output logic          err
);

    localparam int unsigned NQ = 3;
    localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);
    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    logic [DW-1:0] mem    [NQ][DEPTH];
    logic [AW-1:0] wr_ptr [NQ];
    logic [AW-1:0] rd_ptr [NQ];
    logic [AW:0]   cnt    [NQ];

    logic [NQ-1:0] push_v;
    logic [NQ-1:0] pop_v;
    logic          sel_onehot;
    logic          bad_qid;

    // Push/pop qualification uses registered counts only, so a same-cycle pop never
    // frees room for a push and a fresh push is never poppable in its own cycle.
    always_comb begin
        push_v     = '0;
        pop_v      = '0;
        in_rdy     = 1'b0;
        sel_onehot = (sel == 3'b001) || (sel == 3'b010) || (sel == 3'b100);
        bad_qid    = in_vld && (in_qid == 2'd3);
        for (int q = 0; q < NQ; q++) begin
            if (in_qid == 2'(q)) begin
                in_rdy = (cnt[q] != CNT_FULL);
            end
            if (in_vld && (in_qid == 2'(q)) && (cnt[q] != CNT_FULL)) begin
                push_v[q] = 1'b1;
            end
            if ((sel == 3'(1 << q)) && (cnt[q] != '0)) begin
                pop_v[q] = 1'b1;
            end
        end
    end

    // Storage is not reset; stale words are unreachable once pointers clear.
    always_ff @(posedge clk) begin
        for (int q = 0; q < NQ; q++) begin
            if (push_v[q]) begin
                mem[q][wr_ptr[q]] <= in_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int q = 0; q < NQ; q++) begin
                wr_ptr[q] <= '0;
                rd_ptr[q] <= '0;
                cnt[q]    <= '0;
            end
            out_vld  <= 1'b0;
            out_qid  <= '0;
            out_data <= '0;
            err      <= 1'b0;
        end else begin
            out_vld <= |pop_v;
            for (int q = 0; q < NQ; q++) begin
                if (push_v[q]) begin
                    wr_ptr[q] <= wr_ptr[q] + PTR_ONE;
                end
                if (pop_v[q]) begin
                    rd_ptr[q] <= rd_ptr[q] + PTR_ONE;
                    out_qid   <= 2'(q);
                    out_data  <= mem[q][rd_ptr[q]];
                end
                case ({push_v[q], pop_v[q]})
                    2'b10:   cnt[q] <= cnt[q] + CNT_ONE;
                    2'b01:   cnt[q] <= cnt[q] - CNT_ONE;
                    default: cnt[q] <= cnt[q];
                endcase
            end
            if (bad_qid || ((sel != 3'b000) && !sel_onehot)) begin
                err <= 1'b1;
            end
        end
    end

    assign q0_rdy = (cnt[0] != '0);
    assign q1_rdy = (cnt[1] != '0);
    assign q2_rdy = (cnt[2] != '0);
    assign q0_cnt = cnt[0];
    assign q1_cnt = cnt[1];
    assign q2_cnt = cnt[2];

endmodule

// File: tb/tb_rr_queue_bank.sv
// Scoreboard bench for rr_queue_bank: per-queue reference FIFOs predict every pop,
// expected egress words are queued at drive time and checked when out_vld appears.
module tb_rr_queue_bank;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_vld;
    logic [1:0] in_qid;
    logic [7:0] in_data;
    logic       in_rdy;
    logic       q0_rdy, q1_rdy, q2_rdy;
    logic [2:0] sel;
    logic       out_vld;
    logic [1:0] out_qid;
    logic [7:0] out_data;
    logic [2:0] q0_cnt, q1_cnt, q2_cnt;
    logic       err;

    rr_queue_bank #(.DW(8), .DEPTH(4), .AW(2)) dut (
        .clk(clk), .rst(rst),
        .in_vld(in_vld), .in_qid(in_qid), .in_data(in_data), .in_rdy(in_rdy),
        .q0_rdy(q0_rdy), .q1_rdy(q1_rdy), .q2_rdy(q2_rdy),
        .sel(sel),
        .out_vld(out_vld), .out_qid(out_qid), .out_data(out_data),
        .q0_cnt(q0_cnt), .q1_cnt(q1_cnt), .q2_cnt(q2_cnt),
        .err(err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] m0[$];
    logic [7:0] m1[$];
    logic [7:0] m2[$];
    logic [9:0] sb[$];
    logic       exp_err;
    logic [7:0] last_data;
    logic [1:0] last_qid;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int msize(input int q);
        case (q)
            0:       return m0.size();
            1:       return m1.size();
            default: return m2.size();
        endcase
    endfunction

    function automatic logic [7:0] mpop(input int q);
        case (q)
            0:       return m0.pop_front();
            1:       return m1.pop_front();
            default: return m2.pop_front();
        endcase
    endfunction

    task automatic mpush(input int q, input logic [7:0] d);
        case (q)
            0:       m0.push_back(d);
            1:       m1.push_back(d);
            default: m2.push_back(d);
        endcase
    endtask

    task automatic check_state();
        check("err", err, exp_err);
        check("q0_cnt", q0_cnt, msize(0));
        check("q1_cnt", q1_cnt, msize(1));
        check("q2_cnt", q2_cnt, msize(2));
        check("q0_rdy", q0_rdy, msize(0) != 0);
        check("q1_rdy", q1_rdy, msize(1) != 0);
        check("q2_rdy", q2_rdy, msize(2) != 0);
    endtask

    // One clock of stimulus; inputs change on the falling edge, outputs sampled there too.
    task automatic cycle(input logic v, input logic [1:0] qid, input logic [7:0] d, input logic [2:0] s);
        logic       do_push, do_pop;
        int         pq;
        logic [9:0] e;
        in_vld = v; in_qid = qid; in_data = d; sel = s;
        #1;
        check("in_rdy", in_rdy, (qid != 2'd3) && (msize(int'(qid)) != 4));
        do_push = v && (qid != 2'd3) && (msize(int'(qid)) != 4);
        pq = (s == 3'b001) ? 0 : (s == 3'b010) ? 1 : (s == 3'b100) ? 2 : -1;
        do_pop = (pq >= 0) && (msize(pq) != 0);
        if ((v && qid == 2'd3) || (s != 3'b000 && pq < 0)) exp_err = 1'b1;
        if (do_pop) sb.push_back({2'(pq), mpop(pq)});
        if (do_push) mpush(int'(qid), d);
        @(posedge clk);
        @(negedge clk);
        check("out_vld", out_vld, do_pop);
        if (do_pop) begin
            e = sb.pop_front();
            last_qid  = e[9:8];
            last_data = e[7:0];
        end
        check("out_qid", out_qid, last_qid);
        check("out_data", out_data, last_data);
        check_state();
    endtask

    task automatic do_reset();
        rst = 1'b1; in_vld = 1'b0; in_qid = 2'd0; in_data = 8'h00; sel = 3'b000;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        m0.delete(); m1.delete(); m2.delete(); sb.delete();
        exp_err = 1'b0; last_data = 8'h00; last_qid = 2'd0;
        #1;
        check("rst_out_vld", out_vld, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_qid", out_qid, 0);
        check("rst_in_rdy", in_rdy, 1);
        check_state();
    endtask

    initial begin
        logic [2:0] sel_tab [8];
        sel_tab = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100, 3'b011};

        // Reset and idle
        do_reset();
        for (int i = 0; i < 5; i++) cycle(1'b0, 2'd0, 8'h00, 3'b000);

        // Basic FIFO order across two queues
        cycle(1'b1, 2'd0, 8'h11, 3'b000);
        cycle(1'b1, 2'd0, 8'h12, 3'b000);
        cycle(1'b1, 2'd1, 8'h21, 3'b000);
        cycle(1'b0, 2'd0, 8'h00, 3'b001);
        cycle(1'b0, 2'd0, 8'h00, 3'b001);
        cycle(1'b0, 2'd0, 8'h00, 3'b010);

        // Fill q2, reject while full (also with a same-cycle pop), then wrap
        for (int i = 0; i < 4; i++) cycle(1'b1, 2'd2, 8'hA0 + 8'(i), 3'b000);
        cycle(1'b1, 2'd2, 8'hEE, 3'b000);
        cycle(1'b1, 2'd2, 8'hEF, 3'b100);
        cycle(1'b1, 2'd2, 8'hA4, 3'b000);
        for (int i = 0; i < 5; i++) cycle(1'b0, 2'd2, 8'h00, 3'b100);

        // Same-cycle push and pop on q1, then empty pop is silent
        cycle(1'b1, 2'd1, 8'h31, 3'b000);
        cycle(1'b1, 2'd1, 8'h33, 3'b010);
        cycle(1'b0, 2'd0, 8'h00, 3'b010);
        cycle(1'b0, 2'd0, 8'h00, 3'b010);
        cycle(1'b1, 2'd0, 8'h40, 3'b001);

        // Protocol errors are sticky
        cycle(1'b1, 2'd0, 8'h44, 3'b000);
        cycle(1'b0, 2'd0, 8'h00, 3'b011);
        cycle(1'b1, 2'd3, 8'h55, 3'b000);
        for (int i = 0; i < 3; i++) cycle(1'b0, 2'd0, 8'h00, 3'b000);

        // Reset mid-operation discards contents
        cycle(1'b1, 2'd0, 8'h45, 3'b000);
        cycle(1'b1, 2'd0, 8'h46, 3'b000);
        do_reset();
        cycle(1'b0, 2'd0, 8'h00, 3'b001);

        // Random traffic
        for (int i = 0; i < 300; i++) begin
            cycle(1'($urandom_range(0, 1)),
                  ($urandom_range(0, 15) == 0) ? 2'd3 : 2'($urandom_range(0, 2)),
                  8'($urandom),
                  sel_tab[$urandom_range(0, 7)]);
        end
        for (int i = 0; i < 5; i++) cycle(1'b0, 2'd0, 8'h00, 3'b001);
        for (int i = 0; i < 5; i++) cycle(1'b0, 2'd0, 8'h00, 3'b010);
        for (int i = 0; i < 5; i++) cycle(1'b0, 2'd0, 8'h00, 3'b100);
        check("sb_empty", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
